// File: rtl/rs_age_issue_pkg.sv
// Shared constants and types for the age-ordered reservation station.
package rs_age_issue_pkg;

    localparam int RS_DEPTH   = 16;
    localparam int RS_TAG_W   = 5;
    localparam int RS_NUM_CDB = 2;
    localparam int RS_XLEN    = 32;
    localparam int RS_OP_W    = 4;

    // Tag value meaning "operand already holds its value".
    localparam logic [RS_TAG_W-1:0] RS_NULL_TAG = 5'd0;

    // Micro-op classes this station accepts.
    typedef enum logic [RS_OP_W-1:0] {
        OPTYPE_ALU    = 4'd0,
        OPTYPE_BRANCH = 4'd1,
        OPTYPE_JUMP   = 4'd2
    } rs_optype_e;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int rs_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rs_age_issue_if.sv
// Dispatch, result-broadcast and issue signals of the reservation station.
interface rs_age_issue_if #(
    parameter int DEPTH   = rs_age_issue_pkg::RS_DEPTH,
    parameter int TAG_W   = rs_age_issue_pkg::RS_TAG_W,
    parameter int NUM_CDB = rs_age_issue_pkg::RS_NUM_CDB,
    parameter int XLEN    = rs_age_issue_pkg::RS_XLEN,
    parameter int OP_W    = rs_age_issue_pkg::RS_OP_W
) ();
    import rs_age_issue_pkg::*;

    localparam int CNT_W = rs_cnt_width(DEPTH);

    // dispatch side
    logic                     in_valid;
    logic                     in_ready;
    logic [XLEN-1:0]          in_vj;
    logic [XLEN-1:0]          in_vk;
    logic [TAG_W-1:0]         in_qj;
    logic [TAG_W-1:0]         in_qk;
    logic [OP_W-1:0]          in_opcode;
    logic [OP_W-1:0]          in_optype;
    logic [TAG_W-1:0]         in_dest;
    logic [XLEN-1:0]          in_pc;
    logic [XLEN-1:0]          in_imm;
    // result broadcast buses
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_data;
    // issue side
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_vj;
    logic [XLEN-1:0]          out_vk;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_imm;
    logic [OP_W-1:0]          out_opcode;
    logic [OP_W-1:0]          out_optype;
    logic [TAG_W-1:0]         out_dest;
    logic [CNT_W-1:0]         count;

    modport master (
        output in_valid, in_vj, in_vk, in_qj, in_qk, in_opcode, in_optype,
               in_dest, in_pc, in_imm, cdb_valid, cdb_tag, cdb_data, out_ready,
        input  in_ready, out_valid, out_vj, out_vk, out_pc, out_imm,
               out_opcode, out_optype, out_dest, count
    );

    modport slave (
        input  in_valid, in_vj, in_vk, in_qj, in_qk, in_opcode, in_optype,
               in_dest, in_pc, in_imm, cdb_valid, cdb_tag, cdb_data, out_ready,
        output in_ready, out_valid, out_vj, out_vk, out_pc, out_imm,
               out_opcode, out_optype, out_dest, count
    );

endinterface

// File: rtl/rs_age_issue_select.sv
// Oldest-of-ready picker: older[a][b]=1 means entry a was allocated before b.
module rs_age_select #(
    parameter int N     = rs_age_issue_pkg::RS_DEPTH,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]        ready,
    input  logic [N-1:0][N-1:0] older,
    output logic [N-1:0]        grant,
    output logic [IDX_W-1:0]    idx,
    output logic                found
);
    import rs_age_issue_pkg::*;

    logic [N-1:0] blocked_s;

    // An entry wins when no other ready entry is older than it; the age
    // matrix is a strict order so at most one entry wins.
    always_comb begin
        blocked_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                blocked_s[i] = blocked_s[i] | (ready[j] & older[j][i]);
            end
        end
        grant = ready & ~blocked_s;
        idx   = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx = idx | ({IDX_W{grant[i]}} & IDX_W'(i));
        end
        found = |grant;
    end

endmodule

// File: rtl/rs_age_issue.sv
// Reservation station with multi-bus wake-up and oldest-ready issue.
module rs_age_issue #(
    parameter int DEPTH   = rs_age_issue_pkg::RS_DEPTH,
    parameter int TAG_W   = rs_age_issue_pkg::RS_TAG_W,
    parameter int NUM_CDB = rs_age_issue_pkg::RS_NUM_CDB,
    parameter int XLEN    = rs_age_issue_pkg::RS_XLEN,
    parameter int OP_W    = rs_age_issue_pkg::RS_OP_W
) (
    input logic           clk,
    input logic           rst,
    input logic           rdy,
    input logic           flush,
    rs_age_issue_if.slave bus
);
    import rs_age_issue_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = rs_cnt_width(DEPTH);
    localparam logic [TAG_W-1:0] NULL_TAG = {TAG_W{1'b0}};

    // entry storage
    logic [DEPTH-1:0]            valid_r;
    logic [DEPTH-1:0][DEPTH-1:0] older_r;
    logic [XLEN-1:0]             vj_r     [DEPTH];
    logic [XLEN-1:0]             vk_r     [DEPTH];
    logic [XLEN-1:0]             pc_r     [DEPTH];
    logic [XLEN-1:0]             imm_r    [DEPTH];
    logic [TAG_W-1:0]            qj_r     [DEPTH];
    logic [TAG_W-1:0]            qk_r     [DEPTH];
    logic [TAG_W-1:0]            dest_r   [DEPTH];
    logic [OP_W-1:0]             opcode_r [DEPTH];
    logic [OP_W-1:0]             optype_r [DEPTH];

    // output register and occupancy
    logic                        out_valid_r;
    logic [XLEN-1:0]             out_vj_r;
    logic [XLEN-1:0]             out_vk_r;
    logic [XLEN-1:0]             out_pc_r;
    logic [XLEN-1:0]             out_imm_r;
    logic [OP_W-1:0]             out_opcode_r;
    logic [OP_W-1:0]             out_optype_r;
    logic [TAG_W-1:0]            out_dest_r;
    logic [CNT_W-1:0]            count_r;

    // next-state helpers
    logic [DEPTH-1:0]            ready_s;
    logic                        full_s;
    logic [IDX_W-1:0]            alloc_idx_s;
    logic                        dispatch_s;
    logic                        issue_s;
    logic [DEPTH-1:0]            sel_grant_s;
    logic [IDX_W-1:0]            sel_idx_s;
    logic                        sel_found_s;
    logic [DEPTH-1:0]            keep_s;
    logic [DEPTH-1:0]            qj_hit_s;
    logic [DEPTH-1:0]            qk_hit_s;
    logic [XLEN-1:0]             qj_val_s [DEPTH];
    logic [XLEN-1:0]             qk_val_s [DEPTH];
    logic                        byp_j_hit_s;
    logic                        byp_k_hit_s;
    logic [XLEN-1:0]             byp_j_val_s;
    logic [XLEN-1:0]             byp_k_val_s;

    // Searches the result buses for a tag; returns {hit, value}. Channels are
    // scanned from high to low so the lowest matching channel has the last say.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       cv,
        input logic [NUM_CDB*TAG_W-1:0] ct,
        input logic [NUM_CDB*XLEN-1:0]  cd
    );
        logic            hit;
        logic            match;
        logic [XLEN-1:0] val;
        hit = 1'b0;
        val = {XLEN{1'b0}};
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            match = cv[c] && (tag != NULL_TAG) && (ct[c*TAG_W +: TAG_W] == tag);
            hit   = hit | match;
            val   = match ? cd[c*XLEN +: XLEN] : val;
        end
        return {hit, val};
    endfunction

    rs_age_select #(.N(DEPTH), .IDX_W(IDX_W)) u_select (
        .ready (ready_s),
        .older (older_r),
        .grant (sel_grant_s),
        .idx   (sel_idx_s),
        .found (sel_found_s)
    );

    // Readiness, free-slot search and the dispatch/issue decisions, all from
    // pre-edge state.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = valid_r[i] && (qj_r[i] == NULL_TAG) && (qk_r[i] == NULL_TAG);
        end
        full_s      = &valid_r;
        alloc_idx_s = {IDX_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            alloc_idx_s = valid_r[i] ? alloc_idx_s : IDX_W'(i);
        end
        dispatch_s = bus.in_valid && !full_s;
        issue_s    = sel_found_s && (!out_valid_r || bus.out_ready);
        keep_s     = valid_r & ~(issue_s ? sel_grant_s : {DEPTH{1'b0}});
    end

    // Wake-up matches for stored entries and bypass matches for the incoming op.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {qj_hit_s[i], qj_val_s[i]} = cdb_lookup(qj_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            {qk_hit_s[i], qk_val_s[i]} = cdb_lookup(qk_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
        {byp_j_hit_s, byp_j_val_s} = cdb_lookup(bus.in_qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        {byp_k_hit_s, byp_k_val_s} = cdb_lookup(bus.in_qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

    // Station state: reset/flush clear, otherwise wake-up, issue and dispatch.
    always_ff @(posedge clk) begin
        if (rst || (rdy && flush)) begin
            valid_r      <= {DEPTH{1'b0}};
            older_r      <= {(DEPTH*DEPTH){1'b0}};
            out_valid_r  <= 1'b0;
            out_vj_r     <= {XLEN{1'b0}};
            out_vk_r     <= {XLEN{1'b0}};
            out_pc_r     <= {XLEN{1'b0}};
            out_imm_r    <= {XLEN{1'b0}};
            out_opcode_r <= {OP_W{1'b0}};
            out_optype_r <= {OP_W{1'b0}};
            out_dest_r   <= {TAG_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i] && qj_hit_s[i]) begin
                    qj_r[i] <= NULL_TAG;
                    vj_r[i] <= qj_val_s[i];
                end
                if (valid_r[i] && qk_hit_s[i]) begin
                    qk_r[i] <= NULL_TAG;
                    vk_r[i] <= qk_val_s[i];
                end
            end

            if (issue_s) begin
                out_valid_r          <= 1'b1;
                out_vj_r             <= vj_r[sel_idx_s];
                out_vk_r             <= vk_r[sel_idx_s];
                out_pc_r             <= pc_r[sel_idx_s];
                out_imm_r            <= imm_r[sel_idx_s];
                out_opcode_r         <= opcode_r[sel_idx_s];
                out_optype_r         <= optype_r[sel_idx_s];
                out_dest_r           <= dest_r[sel_idx_s];
                valid_r[sel_idx_s]   <= 1'b0;
                for (int j = 0; j < DEPTH; j++) begin
                    older_r[sel_idx_s][j] <= 1'b0;
                    older_r[j][sel_idx_s] <= 1'b0;
                end
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end

            if (dispatch_s) begin
                valid_r[alloc_idx_s]  <= 1'b1;
                vj_r[alloc_idx_s]     <= byp_j_hit_s ? byp_j_val_s : bus.in_vj;
                vk_r[alloc_idx_s]     <= byp_k_hit_s ? byp_k_val_s : bus.in_vk;
                qj_r[alloc_idx_s]     <= byp_j_hit_s ? NULL_TAG : bus.in_qj;
                qk_r[alloc_idx_s]     <= byp_k_hit_s ? NULL_TAG : bus.in_qk;
                pc_r[alloc_idx_s]     <= bus.in_pc;
                imm_r[alloc_idx_s]    <= bus.in_imm;
                opcode_r[alloc_idx_s] <= bus.in_opcode;
                optype_r[alloc_idx_s] <= bus.in_optype;
                dest_r[alloc_idx_s]   <= bus.in_dest;
                // every entry still resident after this edge is older than the newcomer
                for (int j = 0; j < DEPTH; j++) begin
                    older_r[alloc_idx_s][j] <= 1'b0;
                    older_r[j][alloc_idx_s] <= keep_s[j];
                end
            end

            count_r <= count_r + CNT_W'(dispatch_s) - CNT_W'(issue_s);
        end
    end

    assign bus.in_ready   = !full_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_vj     = out_vj_r;
    assign bus.out_vk     = out_vk_r;
    assign bus.out_pc     = out_pc_r;
    assign bus.out_imm    = out_imm_r;
    assign bus.out_opcode = out_opcode_r;
    assign bus.out_optype = out_optype_r;
    assign bus.out_dest   = out_dest_r;
    assign bus.count      = count_r;

endmodule
